dmem_arbiter: RTL and testbench

- Shares the single 64-bit data memory port (Memoria64) between two requesters: the core's load/store path (port c) and a DMA/program loader (port d).
- Sits between the control/datapath and the data memory, and drives the memory's raddress, waddress, Datain and Wr.
- Serialises one transaction at a time with a req/gnt/rvalid handshake.
- Arbitration is round-robin, or fixed priority to the core when configured.

---
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per requester (core, DMA).
// The requester drives req/we/addr/wdata and receives gnt/rvalid/rdata.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data memory port between the core (c) and the DMA/loader (d),
// one transaction at a time, round-robin or core-first arbitration.
//
// state  | meaning
// IDLE   | sample requests, latch winner's id/we/addr/wdata
// ACCESS | winner's gnt; address and write data on the memory, mem_wr for stores
// WAIT   | MEM_LAT cycles of read latency; data captured in the last one
// RESP   | winner's rvalid with the captured read data
module dmem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     c,
  dmem_arbiter_if.slave     d,
  output logic [ADDR_W-1:0] mem_raddress,
  output logic [ADDR_W-1:0] mem_waddress,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            stateQ, stateD;
  logic              winnerQ;    // 0 = core, 1 = DMA
  logic              lastGrantQ;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [CNT_W-1:0]  latCnt;
  logic [DATA_W-1:0] cRdataQ, dRdataQ;
  logic              pickD;

  // Tie-break: core when fixed priority, otherwise whoever was not granted last.
  always_comb begin
    pickD = d.req;
    if (c.req && d.req) begin
      pickD = (FIXED_PRIO != 0) ? 1'b0 : !lastGrantQ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (c.req || d.req) stateD = ACCESS;
      ACCESS:  stateD = weQ ? IDLE : WAIT;
      WAIT:    if (latCnt == '0) stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    c.gnt    = (stateQ == ACCESS) && !winnerQ;
    d.gnt    = (stateQ == ACCESS) &&  winnerQ;
    c.rvalid = (stateQ == RESP)   && !winnerQ;
    d.rvalid = (stateQ == RESP)   &&  winnerQ;
    mem_wr   = (stateQ == ACCESS) &&  weQ;
    busy     = (stateQ != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      winnerQ    <= 1'b0;
      lastGrantQ <= 1'b1;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      latCnt     <= '0;
      cRdataQ    <= '0;
      dRdataQ    <= '0;
    end else begin
      if (stateQ == IDLE && (c.req || d.req)) begin
        winnerQ    <= pickD;
        lastGrantQ <= pickD;
        weQ        <= pickD ? d.we    : c.we;
        addrQ      <= pickD ? d.addr  : c.addr;
        wdataQ     <= pickD ? d.wdata : c.wdata;
      end
      if (stateQ == ACCESS) begin
        latCnt <= CNT_W'(MEM_LAT - 1);
      end else if (stateQ == WAIT && latCnt != '0) begin
        latCnt <= latCnt - 1'b1;
      end
      if (stateQ == WAIT && latCnt == '0) begin
        if (winnerQ) dRdataQ <= mem_dataout;
        else         cRdataQ <= mem_dataout;
      end
    end
  end

  assign mem_raddress = addrQ;
  assign mem_waddress = addrQ;
  assign mem_datain   = wdataQ;
  assign c.rdata      = cRdataQ;
  assign d.rdata      = dRdataQ;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (round-robin lat 1, fixed-priority lat 1,
// round-robin lat 3), each with a small pipelined memory model.
module tb_dmem_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic memInit;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic        req   [3][2];
  logic        we    [3][2];
  logic [63:0] addr  [3][2];
  logic [63:0] wdata [3][2];
  logic        gnt   [3][2];
  logic        rvalid[3][2];
  logic [63:0] rdata [3][2];
  logic [63:0] mRaddr[3], mWaddr[3], mDin[3], mDout[3];
  logic        mWr[3], busy[3];

  function automatic logic [63:0] initVal(input int k, input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(k) << 32) | 64'(i);
  endfunction

  function automatic int latOf(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  genvar g;
  for (g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int FP  = (g == 1) ? 1 : 0;
    dmem_arbiter_if cIf ();
    dmem_arbiter_if dIf ();
    assign cIf.req = req[g][0];  assign cIf.we = we[g][0];
    assign cIf.addr = addr[g][0]; assign cIf.wdata = wdata[g][0];
    assign dIf.req = req[g][1];  assign dIf.we = we[g][1];
    assign dIf.addr = addr[g][1]; assign dIf.wdata = wdata[g][1];
    assign gnt[g][0] = cIf.gnt;  assign rvalid[g][0] = cIf.rvalid; assign rdata[g][0] = cIf.rdata;
    assign gnt[g][1] = dIf.gnt;  assign rvalid[g][1] = dIf.rvalid; assign rdata[g][1] = dIf.rdata;

    dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(LAT), .FIXED_PRIO(FP)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .c            (cIf),
      .d            (dIf),
      .mem_raddress (mRaddr[g]),
      .mem_waddress (mWaddr[g]),
      .mem_datain   (mDin[g]),
      .mem_wr       (mWr[g]),
      .mem_dataout  (mDout[g]),
      .busy         (busy[g])
    );

    // Memory model: write at clock edge, read data delayed LAT cycles after the address.
    logic [63:0] mem  [256];
    logic [63:0] pipe [3];
    always @(posedge clock) begin
      if (memInit) begin
        for (int i = 0; i < 256; i++) mem[i] <= initVal(g, i);
      end else if (mWr[g]) begin
        mem[mWaddr[g][7:0]] <= mDin[g];
      end
      pipe[0] <= mem[mRaddr[g][7:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mDout[g] = pipe[LAT-1];
  end

  typedef struct { int dut; int port; logic [63:0] data; } exp_t;
  typedef struct { int port; logic we; logic [63:0] addr; logic [63:0] wdata; logic [63:0] expData; } vec_t;

  exp_t        sb[$];
  int          gLog[$];
  logic [63:0] refMem[3][256];
  int          nTests = 0;
  int          nFail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit allZero(input int k);
    return !gnt[k][0] && !gnt[k][1] && !rvalid[k][0] && !rvalid[k][1] &&
           rdata[k][0] == 64'h0 && rdata[k][1] == 64'h0 && mRaddr[k] == 64'h0 &&
           mWaddr[k] == 64'h0 && mDin[k] == 64'h0 && !mWr[k] && !busy[k];
  endfunction

  task automatic waitIdle(input int k);
    int t;
    t = 0;
    while (busy[k] && t < 50) begin
      @(negedge clock);
      t++;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One transaction; called on a falling edge. Returns at gnt for writes, at rvalid for reads.
  task automatic doTxn(input int k, input int p, input logic w, input logic [63:0] a,
                       input logic [63:0] dIn, input logic [63:0] expD, input bit timed,
                       output int gCyc);
    int n0, t;
    req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = dIn;
    n0 = cyc;
    if (!w) sb.push_back('{k, p, expD});
    t = 0;
    do begin @(negedge clock); t++; end while (!gnt[k][p] && t < 100);
    gCyc = cyc;
    chk($sformatf("gntSeen d%0d p%0d", k, p), 64'(gnt[k][p]), 64'd1);
    chk($sformatf("memWr d%0d p%0d", k, p), 64'(mWr[k]), 64'(w));
    chk($sformatf("memRaddr d%0d p%0d", k, p), mRaddr[k], a);
    chk($sformatf("memWaddr d%0d p%0d", k, p), mWaddr[k], a);
    if (w) chk($sformatf("memDatain d%0d p%0d", k, p), mDin[k], dIn);
    if (timed) chk($sformatf("gntLatency d%0d p%0d", k, p), 64'(gCyc - n0), 64'd1);
    req[k][p] = 1'b0;
    if (w) begin
      refMem[k][a[7:0]] = dIn;
    end else begin
      t = 0;
      do begin @(negedge clock); t++; end while (!rvalid[k][p] && t < 50);
      chk($sformatf("rvalidSeen d%0d p%0d", k, p), 64'(rvalid[k][p]), 64'd1);
      if (timed) chk($sformatf("rvalidLatency d%0d p%0d", k, p), 64'(cyc - n0), 64'(2 + latOf(k)));
    end
  endtask

  // Scoreboard and protocol invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          if (rvalid[k][p]) begin
            int idx;
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].dut == k && sb[i].port == p) idx = i;
            if (idx < 0) begin
              nTests++; nFail++;
              $display("FAIL unexpectedRvalid d%0d p%0d: got rvalid 1, expected 0 (cycle %0d)", k, p, cyc);
            end else begin
              chk($sformatf("rdata d%0d p%0d", k, p), rdata[k][p], sb[idx].data);
              sb.delete(idx);
            end
          end
        end
        chk($sformatf("dualGnt d%0d", k), 64'(gnt[k][0] & gnt[k][1]), 64'd0);
        chk($sformatf("dualRvalid d%0d", k), 64'(rvalid[k][0] & rvalid[k][1]), 64'd0);
        chk($sformatf("wrOutsideAccess d%0d", k), 64'(mWr[k] & ~(gnt[k][0] | gnt[k][1])), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  vec_t        tbl[10];
  logic [63:0] snap;
  int          gc, gd, gc2, gd2, gc0, gc1, n0, t, bc, bad, rc, altBad;
  int          cg[3];

  initial begin
    tbl[0] = '{0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0};
    tbl[1] = '{1, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D};
    tbl[2] = '{1, 1'b1, 64'hFFFF_0000_0000_0020, 64'h0123_4567_89AB_CDEF, 64'h0};
    tbl[3] = '{0, 1'b0, 64'hFFFF_0000_0000_0020, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[4] = '{1, 1'b0, 64'h30, 64'h0, 64'hA5A5_0000_0000_0030};
    tbl[5] = '{0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[6] = '{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[7] = '{0, 1'b0, 64'hF0, 64'h0, 64'hA5A5_0000_0000_00F0};
    tbl[8] = '{0, 1'b1, 64'h0, 64'h0, 64'h0};
    tbl[9] = '{0, 1'b0, 64'h0, 64'h0, 64'h0};

    reset = 1'b1; memInit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0;
      end
      for (int i = 0; i < 256; i++) refMem[k][i] = initVal(k, i);
    end
    repeat (3) @(negedge clock);
    memInit = 1'b0; reset = 1'b0;

    // Reset state held while idle
    repeat (5) begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) chk($sformatf("resetIdleZero d%0d", k), 64'(allZero(k)), 64'd1);
    end

    // Single uncontended transactions on the round-robin, latency-1 instance
    for (int v = 0; v < 10; v++) begin
      waitIdle(0);
      snap = rdata[0][1 - tbl[v].port];
      doTxn(0, tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].expData, 1'b1, gc);
      chk($sformatf("otherRdataKept v%0d", v), rdata[0][1 - tbl[v].port], snap);
      if (!tbl[v].we) begin
        @(negedge clock);
        chk($sformatf("rdataHold v%0d", v), rdata[0][tbl[v].port], tbl[v].expData);
      end
    end

    // Round-robin tie: after reset the core wins, then the DMA at the next IDLE
    waitIdle(0);
    doReset();
    fork
      doTxn(0, 0, 1'b0, 64'h8,  64'h0, refMem[0][8'h08], 1'b0, gc);
      doTxn(0, 1, 1'b0, 64'h18, 64'h0, refMem[0][8'h18], 1'b0, gd);
    join
    chk("rrFirstPairOrder", 64'(gd - gc), 64'd4);
    waitIdle(0);
    fork
      doTxn(0, 0, 1'b0, 64'h8,  64'h0, refMem[0][8'h08], 1'b0, gc2);
      doTxn(0, 1, 1'b0, 64'h18, 64'h0, refMem[0][8'h18], 1'b0, gd2);
    join
    chk("rrSecondPairOrder", 64'(gd2 - gc2), 64'd4);

    // Fixed priority: back-to-back core writes hold off a waiting DMA
    waitIdle(1);
    fork
      begin
        for (int i = 0; i < 3; i++)
          doTxn(1, 0, 1'b1, 64'h60 + 64'(8 * i), {32'hC0C0_0000, 32'(i)}, 64'h0, 1'b0, cg[i]);
      end
      doTxn(1, 1, 1'b1, 64'h40, 64'hD1D1_0000_0000_0040, 64'h0, 1'b0, gd);
    join
    chk("fpCoreBackToBack1", 64'(cg[1] - cg[0]), 64'd2);
    chk("fpCoreBackToBack2", 64'(cg[2] - cg[1]), 64'd2);
    chk("fpDmaAfterCore", 64'(gd - cg[2]), 64'd2);
    waitIdle(1);
    doTxn(1, 0, 1'b0, 64'h70, 64'h0, refMem[1][8'h70], 1'b1, gc);
    waitIdle(1);
    doTxn(1, 1, 1'b0, 64'h40, 64'h0, refMem[1][8'h40], 1'b1, gd);

    // Latency 3: busy span, address stability, rvalid timing
    waitIdle(2);
    sb.push_back('{2, 0, refMem[2][8'h50]});
    req[2][0] = 1'b1; we[2][0] = 1'b0; addr[2][0] = 64'h50;
    n0 = cyc; bc = 0; bad = 0; rc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (gnt[2][0]) req[2][0] = 1'b0;
      if (busy[2]) begin
        bc++;
        if (mRaddr[2] !== 64'h50) bad++;
      end
      if (rvalid[2][0]) rc = cyc;
    end
    chk("lat3BusyCycles", 64'(bc), 64'd5);
    chk("lat3RaddrStable", 64'(bad), 64'd0);
    chk("lat3RvalidCycle", 64'(rc - n0), 64'd5);
    waitIdle(2);
    doTxn(2, 1, 1'b1, 64'h58, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, gd);
    waitIdle(2);
    doTxn(2, 1, 1'b0, 64'h58, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, gd);

    // Reset during WAIT of a DMA read aborts it; the held request is served afterwards
    waitIdle(0);
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 64'h18;
    t = 0;
    do begin @(negedge clock); t++; end while (!gnt[0][1] && t < 20);
    chk("abortGnt", 64'(gnt[0][1]), 64'd1);
    @(negedge clock);
    chk("abortInWait", 64'({busy[0], rvalid[0][1]}), 64'b10);
    reset = 1'b1;
    @(negedge clock);
    chk("abortAllZero", 64'(allZero(0)), 64'd1);
    sb.push_back('{0, 1, refMem[0][8'h18]});
    n0 = cyc;
    reset = 1'b0;
    t = 0;
    do begin @(negedge clock); t++; end while (!gnt[0][1] && t < 20);
    chk("abortRegrant", 64'(gnt[0][1]), 64'd1);
    chk("abortRegrantCycle", 64'(cyc - n0), 64'd1);
    req[0][1] = 1'b0;
    t = 0;
    do begin @(negedge clock); t++; end while (!rvalid[0][1] && t < 20);
    chk("abortRetryRvalid", 64'(rvalid[0][1]), 64'd1);

    // 100 contended writes: grants must alternate; then read every slot back
    waitIdle(0);
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          doTxn(0, 0, 1'b1, 64'(((2 * i) % 32) * 8), {32'hC0DE_0000, 32'(i)}, 64'h0, 1'b0, gc0);
          gLog.push_back(0);
        end
      end
      begin
        for (int i = 0; i < 50; i++) begin
          doTxn(0, 1, 1'b1, 64'(((2 * i + 1) % 32) * 8), {32'hD0A0_0000, 32'(i)}, 64'h0, 1'b0, gc1);
          gLog.push_back(1);
        end
      end
    join
    altBad = 0;
    for (int i = 1; i < gLog.size(); i++) if (gLog[i] == gLog[i-1]) altBad++;
    chk("altGrantCount", 64'(gLog.size()), 64'd100);
    chk("altGrantAlternate", 64'(altBad), 64'd0);
    for (int s = 0; s < 32; s++) begin
      waitIdle(0);
      doTxn(0, s % 2, 1'b0, 64'(s * 8), 64'h0, refMem[0][s * 8], 1'b1, gc);
    end

    for (int k = 0; k < 3; k++) waitIdle(k);
    repeat (5) @(negedge clock);
    chk("scoreboardDrained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
